dsp_scan_ctrl: RTL and testbench
================================

DSP_SCAN_CTRL -- requirements
Module: dsp_scan_ctrl

Interface
REQ-001 Parameter SHIFT_LEN, default 16: shift cycles per scan operation; legal range 1..1023.
REQ-002 Parameter LANES, default 10: parallel scan lanes, matching the DSP scan port width.
REQ-003 clock  input  1  sole clock; the DSP scan_clk is tied externally to this clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a scan operation; ignored unless the controller is idle.
REQ-006 wr_data  input  LANES  next word to shift into the chain.
REQ-007 wr_valid  input  1  wr_data is valid.
REQ-008 wr_ready  output  1  the word on wr_data is consumed this cycle.
REQ-009 rd_data  output  LANES  captured chain word.
REQ-010 rd_valid  output  1  rd_data is valid.
REQ-011 rd_ready  input  1  sink accepts rd_data.
REQ-012 busy  output  1  an operation is in progress.
REQ-013 done  output  1  one-cycle pulse when the operation completes.
REQ-014 dsp_scan_i  output  LANES  drives the DSP scan_i port.
REQ-015 dsp_scan_o  input  LANES  driven by the DSP scan_o port.
REQ-016 dsp_scan_en  output  1  DSP scan_en; high only on shift cycles.
REQ-017 dsp_scan_mode  output  1  DSP scan_mode; high from the start cycle through the done cycle.
REQ-018 dsp_scan_reset  output  1  DSP scan_reset; high for exactly the first cycle after start is accepted.

Function
REQ-019 FSM states are IDLE, PREP, SHIFT and FLUSH.
- IDLE to PREP on start.
- PREP to SHIFT after 1 cycle.
- SHIFT to FLUSH when the last shift fires.
- FLUSH to IDLE when the rd handshake of the final word completes.
REQ-020 In PREP, dsp_scan_reset=1, dsp_scan_en=0 and wr_ready=0.
REQ-021 A shift fires in SHIFT when wr_valid=1 and (rd_valid=0 or rd_ready=1); wr_ready and dsp_scan_en equal this fire condition combinationally.
REQ-022 On a shift, dsp_scan_i=wr_data in the same cycle, and dsp_scan_o is registered into rd_data with rd_valid=1 on the next cycle.
REQ-023 When a shift fires, rd_valid remains 1; otherwise an rd handshake (rd_valid and rd_ready) clears rd_valid.
REQ-024 dsp_scan_i holds 0 whenever no shift fires.
REQ-025 The shift counter runs 0..SHIFT_LEN-1, increments per shift, and the shift at count SHIFT_LEN-1 is the last; the counter does not wrap.
REQ-026 done pulses in the cycle FLUSH exits to IDLE.
REQ-027 busy=1 in every state except IDLE.
REQ-028 Exactly SHIFT_LEN words are accepted and SHIFT_LEN words are emitted per operation, in order.
REQ-029 A stalled wr_valid or rd_ready freezes the chain with dsp_scan_en=0; no word is ever lost or duplicated.
REQ-030 start while busy=1 has no effect.
REQ-031 For SHIFT_LEN=1, PREP goes to SHIFT, then to FLUSH after one shift.

Reset
REQ-032 On reset:
- FSM goes to IDLE and the counter to 0.
- rd_valid, done, busy, wr_ready, dsp_scan_en, dsp_scan_mode and dsp_scan_reset go to 0.
- rd_data and dsp_scan_i go to 0.
REQ-033 Reset mid-operation aborts the operation immediately; the partial chain content is undefined, and no done pulse is produced.

Configuration
REQ-034 With DSP_SCAN_PARITY_EN defined:
- Output parity_err (1 bit) is added.
- A per-lane XOR of all captured words is accumulated and cleared in PREP.
- parity_err is valid with done; it is 1 if any lane's accumulated parity differs from the XOR of that lane's shifted-in words.
- parity_err is held until the next start.
REQ-035 Without DSP_SCAN_PARITY_EN, the port and its logic are absent; all other behaviour is identical.

Structure
REQ-036 Shared package dsp_scan_pkg holds:
- the state enum;
- the LANES default;
- the counter-width function clog2(SHIFT_LEN).
REQ-037 One sub-module, dsp_scan_cnt, implements the shift counter with last-flag; everything else is in dsp_scan_ctrl.

Verification
REQ-038 SHIFT_LEN=16, wr_valid and rd_ready held 1, DSP model is a 16-deep per-lane shift chain, inputs 0x001..0x010:
- rd_data returns the prior chain content;
- a second operation returns 0x001..0x010 in order;
- done occurs 19 cycles after start.
REQ-039 wr_valid is deasserted for 5 cycles mid-SHIFT: dsp_scan_en=0 for those 5 cycles, the counter holds, and output order is intact.
REQ-040 rd_ready is held 0 while rd_valid=1: wr_ready=0 and dsp_scan_en=0 until rd_ready=1, with no duplicate rd_data words.
REQ-041 Start pulsed again at shift 7: ignored, the count completes at 16, and exactly one done pulse occurs.
REQ-042 Reset asserted at shift 9: the next cycle shows busy=0, rd_valid=0 and dsp_scan_mode=0, with no done pulse; a following start runs a full 16-shift operation.
REQ-043 With DSP_SCAN_PARITY_EN defined, a DSP model that flips lane 3 on one bit gives parity_err=1 at done; a clean chain gives parity_err=0.

Source files
------------

// File: rtl/dsp_scan_pkg.sv
// dsp_scan_pkg -- definitions shared by the DSP scan controller files.
// Contents:
//   scan_state_e  : controller FSM states (IDLE, PREP, SHIFT, FLUSH)
//   LANES_DEFAULT : default scan lane count (matches the DSP scan port width)
//   clog2()       : shift counter width for a given SHIFT_LEN
package dsp_scan_pkg;

  localparam int LANES_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PREP  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_FLUSH = 2'd3
  } scan_state_e;

  // Ceil(log2(value)), never less than 1, so that SHIFT_LEN=1 still
  // gets a one-bit counter.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dsp_scan_cnt.sv
// dsp_scan_cnt -- shift counter for the DSP scan controller.
// Counts accepted shifts from 0 up to SHIFT_LEN-1 and flags the last one.
// The counter saturates at SHIFT_LEN-1; it never wraps.
// Ports:
//   i_clock  : clock
//   i_reset  : synchronous active-high reset (count -> 0)
//   i_clear  : synchronous clear (asserted while preparing an operation)
//   i_inc    : one shift fired this cycle
//   o_last   : current count is SHIFT_LEN-1 (next shift is the final one)
module dsp_scan_cnt
  import dsp_scan_pkg::*;
#(
  parameter int SHIFT_LEN = 16
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_last
);

  localparam int CW = clog2(SHIFT_LEN);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == CW'(SHIFT_LEN - 1));
  assign o_last = w_last;

  // Shift count register: clear, increment on a shift, hold at the last value.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= {CW{1'b0}};
    end else if (i_clear) begin
      r_count <= {CW{1'b0}};
    end else if (i_inc && !w_last) begin
      r_count <= r_count + CW'(1'b1);
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/dsp_scan_ctrl.sv
// dsp_scan_ctrl -- drives a DSP scan chain: shifts SHIFT_LEN words from the
// wr stream into dsp_scan_i while capturing dsp_scan_o into the rd stream.
// Optional feature macro: DSP_SCAN_PARITY_EN (adds o_parity_err).
// Ports:
//   i_clock, i_reset           : clock, synchronous active-high reset
//   i_start                    : start pulse (honoured only when idle)
//   i_wr_data/i_wr_valid       : inbound words, o_wr_ready = consumed now
//   o_rd_data/o_rd_valid       : captured words, i_rd_ready = sink accepts
//   o_busy, o_done             : operation in progress / completion pulse
//   o_dsp_scan_i/i_dsp_scan_o  : DSP chain data in / out
//   o_dsp_scan_en              : DSP shift enable (only on shift cycles)
//   o_dsp_scan_mode            : high from the start cycle through done
//   o_dsp_scan_reset           : high in the single prepare cycle
//   o_parity_err               : (DSP_SCAN_PARITY_EN) lane parity check
module dsp_scan_ctrl
  import dsp_scan_pkg::*;
#(
  parameter int SHIFT_LEN = 16,
  parameter int LANES     = LANES_DEFAULT
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [LANES-1:0] i_wr_data,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  output logic [LANES-1:0] o_rd_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [LANES-1:0] o_dsp_scan_i,
  input  logic [LANES-1:0] i_dsp_scan_o,
  output logic             o_dsp_scan_en,
  output logic             o_dsp_scan_mode,
  output logic             o_dsp_scan_reset
`ifdef DSP_SCAN_PARITY_EN
  ,
  output logic             o_parity_err
`endif
);

  scan_state_e      r_state;
  scan_state_e      w_state_nxt;
  logic [LANES-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_fire;
  logic             w_rd_hs;
  logic             w_last;
  logic             w_clear;

  // A shift needs a word to consume and room in the rd register (either
  // empty or being drained this cycle). Gated by reset so nothing is
  // reported as consumed in the cycle the controller is being reset.
  assign w_fire  = (r_state == ST_SHIFT) && i_wr_valid &&
                   (!r_rd_valid || i_rd_ready) && !i_reset;
  assign w_rd_hs = r_rd_valid && i_rd_ready;
  assign w_clear = (r_state == ST_PREP);

  dsp_scan_cnt #(
    .SHIFT_LEN (SHIFT_LEN)
  ) u_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (w_clear),
    .i_inc   (w_fire),
    .o_last  (w_last)
  );

  // FSM state register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and completion detect.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_PREP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PREP: begin
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_fire && w_last) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_FLUSH: begin
        // The final captured word is sitting in rd_data; leave once drained.
        if (w_rd_hs) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_FLUSH;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Capture register: a shift loads the chain output; a drain without a
  // concurrent shift empties it. Done is registered from the FLUSH exit.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rd_data  <= {LANES{1'b0}};
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_fire) begin
        r_rd_data  <= i_dsp_scan_o;
        r_rd_valid <= 1'b1;
      end else if (w_rd_hs) begin
        r_rd_data  <= r_rd_data;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_data  <= r_rd_data;
        r_rd_valid <= r_rd_valid;
      end
    end
  end

  assign o_wr_ready       = w_fire;
  assign o_dsp_scan_en    = w_fire;
  assign o_dsp_scan_i     = w_fire ? i_wr_data : {LANES{1'b0}};
  assign o_rd_data        = r_rd_data;
  assign o_rd_valid       = r_rd_valid;
  assign o_done           = r_done;
  assign o_busy           = (r_state != ST_IDLE);
  assign o_dsp_scan_reset = (r_state == ST_PREP);
  // Mode covers the accepting start cycle (still IDLE) and the done cycle
  // (already back in IDLE) in addition to every busy state.
  assign o_dsp_scan_mode  = (r_state != ST_IDLE) ||
                            (i_start && !i_reset) || r_done;

`ifdef DSP_SCAN_PARITY_EN
  logic [LANES-1:0] r_par_cap;
  logic [LANES-1:0] r_par_shf;
  logic             r_parity_err;

  // Per-lane parity of captured and shifted-in words for this operation.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_par_cap <= {LANES{1'b0}};
      r_par_shf <= {LANES{1'b0}};
    end else if (w_clear) begin
      r_par_cap <= {LANES{1'b0}};
      r_par_shf <= {LANES{1'b0}};
    end else if (w_fire) begin
      r_par_cap <= r_par_cap ^ i_dsp_scan_o;
      r_par_shf <= r_par_shf ^ i_wr_data;
    end else begin
      r_par_cap <= r_par_cap;
      r_par_shf <= r_par_shf;
    end
  end

  // Parity verdict: produced alongside done, held until the next start.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_parity_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && i_start) begin
      r_parity_err <= 1'b0;
    end else if (w_done_nxt) begin
      r_parity_err <= |(r_par_cap ^ r_par_shf);
    end else begin
      r_parity_err <= r_parity_err;
    end
  end

  assign o_parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_dsp_scan_ctrl.sv
// tb_dsp_scan_ctrl -- scoreboard bench for dsp_scan_ctrl (SHIFT_LEN=16,
// LANES=10) against a 16-deep per-lane DSP shift chain model. Words accepted
// on the wr side are pushed behind the chain's known contents; every rd
// handshake pops and compares the oldest entry.
module tb_dsp_scan_ctrl;

  localparam int LANES = 10;
  localparam int SLEN  = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic [LANES-1:0] wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [LANES-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             busy;
  logic             done;
  logic [LANES-1:0] scan_i;
  logic [LANES-1:0] scan_o;
  logic             scan_en;
  logic             scan_mode;
  logic             scan_rst;
`ifdef DSP_SCAN_PARITY_EN
  logic             parity_err;
  logic             flip;
  int               flip_at;
`endif

  logic             dsp_load;
  logic [LANES-1:0] chain [SLEN];
  logic [LANES-1:0] exp_q [$];
  logic [LANES-1:0] xor_in;
  logic [LANES-1:0] xor_out;
  int               n_checks;
  int               n_pass;
  int               cyc;
  int               n_acc;
  int               n_rd;
  int               done_cnt;
  int               done_cyc;
  bit               quiet;

  dsp_scan_ctrl #(
    .SHIFT_LEN (SLEN),
    .LANES     (LANES)
  ) dut (
    .i_clock          (clk),
    .i_reset          (reset),
    .i_start          (start),
    .i_wr_data        (wr_data),
    .i_wr_valid       (wr_valid),
    .o_wr_ready       (wr_ready),
    .o_rd_data        (rd_data),
    .o_rd_valid       (rd_valid),
    .i_rd_ready       (rd_ready),
    .o_busy           (busy),
    .o_done           (done),
    .o_dsp_scan_i     (scan_i),
    .i_dsp_scan_o     (scan_o),
    .o_dsp_scan_en    (scan_en),
    .o_dsp_scan_mode  (scan_mode),
    .o_dsp_scan_reset (scan_rst)
`ifdef DSP_SCAN_PARITY_EN
    ,
    .o_parity_err     (parity_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DSP chain model: tail drives scan_o; optional single-word lane-3 fault.
`ifdef DSP_SCAN_PARITY_EN
  assign scan_o = chain[SLEN-1] ^ (flip ? 10'h008 : 10'h000);
`else
  assign scan_o = chain[SLEN-1];
`endif

  always @(posedge clk) begin
    if (dsp_load) begin
      for (int i = 0; i < SLEN; i++) chain[i] <= LANES'(32'h200 + i);
    end else if (scan_en) begin
      for (int i = SLEN - 1; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= scan_i;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, expv, cyc);
  endtask

  // Known chain contents: tail (chain[15]) emerges first.
  task automatic init_sb();
    exp_q.delete();
    for (int i = SLEN - 1; i >= 0; i--) exp_q.push_back(LANES'(32'h200 + i));
  endtask

  // One clock cycle: observe handshakes just before the edge, then advance.
  task automatic step();
    logic [LANES-1:0] e;
    #1;
    if (rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e));
        xor_out ^= e;
        n_rd++;
      end
    end
    if (wr_valid && wr_ready) begin
      chk("scan_i", 32'(scan_i), 32'(wr_data));
      exp_q.push_back(wr_data);
      xor_in ^= wr_data;
      n_acc++;
`ifdef DSP_SCAN_PARITY_EN
      if (flip) exp_q[0] = exp_q[0] ^ 10'h008;
`endif
    end
    if (quiet) begin
      chk("stall_scan_en", 32'(scan_en), 32'd0);
      chk("stall_wr_ready", 32'(wr_ready), 32'd0);
      chk("stall_scan_i", 32'(scan_i), 32'd0);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      chk("mode_at_done", 32'(scan_mode), 32'd1);
      chk("busy_at_done", 32'(busy), 32'd0);
`ifdef DSP_SCAN_PARITY_EN
      chk("parity_err", 32'(parity_err), 32'(|(xor_out ^ xor_in)));
`endif
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic preload();
    dsp_load = 1'b1;
    step();
    dsp_load = 1'b0;
    init_sb();
  endtask

  // One operation with optional wr stall, rd stall, re-start and abort points.
  task automatic run_op(input logic [LANES-1:0] base, input int wr_stall_at,
                        input int rd_stall_at, input int restart_at, input int abort_at);
    int guard;
    int wr_hold;
    int rd_hold;
    int start_cyc;
    int exp_lat;
    bit wr_stalled;
    bit rd_stalled;
    bit restarted;
    n_acc = 0; n_rd = 0; done_cnt = 0; xor_in = '0; xor_out = '0;
    wr_hold = 0; rd_hold = 0; exp_lat = 19; guard = 0;
    wr_stalled = 1'b0; rd_stalled = 1'b0; restarted = 1'b0;
    wr_valid = 1'b1; rd_ready = 1'b1; wr_data = base; start = 1'b1; start_cyc = cyc;
    #1;
    chk("mode_at_start", 32'(scan_mode), 32'd1);
    chk("busy_at_start", 32'(busy), 32'd0);
    step();
    start = 1'b0;
    chk("prep_scan_reset", 32'(scan_rst), 32'd1);
    chk("prep_scan_en", 32'(scan_en), 32'd0);
    chk("prep_wr_ready", 32'(wr_ready), 32'd0);
    chk("prep_busy", 32'(busy), 32'd1);
    while (done_cnt == 0 && guard < 200) begin
      guard++;
      start = 1'b0;
      if (n_acc == wr_stall_at && !wr_stalled) begin
        wr_hold = 5; wr_stalled = 1'b1; exp_lat += 5;
      end
      if (n_rd == rd_stall_at && !rd_stalled) begin
        rd_hold = 4; rd_stalled = 1'b1; exp_lat += 4;
      end
      if (n_acc == restart_at && !restarted) begin
        start = 1'b1; restarted = 1'b1;
      end
      if (n_acc == abort_at) begin
        quiet = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        wr_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rd_valid", 32'(rd_valid), 32'd0);
        chk("abort_mode", 32'(scan_mode), 32'd0);
        repeat (4) step();
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        return;
      end
      wr_valid = (wr_hold == 0);
      rd_ready = (rd_hold == 0);
      quiet    = (wr_hold > 0) || (rd_hold > 0);
      if (wr_hold > 0) wr_hold--;
      if (rd_hold > 0) rd_hold--;
      wr_data = base + LANES'(n_acc);
`ifdef DSP_SCAN_PARITY_EN
      flip = (n_acc == flip_at) && !quiet;
`endif
      step();
    end
    quiet = 1'b0; start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b1;
`ifdef DSP_SCAN_PARITY_EN
    flip = 1'b0;
`endif
    chk("done_latency", 32'(done_cyc - start_cyc), 32'(exp_lat));
    chk("words_in", 32'(n_acc), 32'(SLEN));
    chk("words_out", 32'(n_rd), 32'(SLEN));
    repeat (3) step();
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; n_acc = 0; n_rd = 0;
    done_cnt = 0; done_cyc = 0; quiet = 1'b0; xor_in = '0; xor_out = '0;
    reset = 1'b1; start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    wr_data = '0; dsp_load = 1'b1;
`ifdef DSP_SCAN_PARITY_EN
    flip = 1'b0; flip_at = -1;
`endif
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    dsp_load = 1'b0;
    init_sb();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_scan_en", 32'(scan_en), 32'd0);
    chk("rst_scan_mode", 32'(scan_mode), 32'd0);
    chk("rst_scan_reset", 32'(scan_rst), 32'd0);
    chk("rst_scan_i", 32'(scan_i), 32'd0);
    step();

    // Prior chain contents come back, then the first operation's words.
    run_op(10'h001, -1, -1, -1, -1);
    run_op(10'h001, -1, -1, -1, -1);
    // wr_valid gap of 5 cycles mid-shift.
    run_op(10'h040, 5, -1, -1, -1);
    // rd_ready held low mid-stream plus an ignored start at shift 7.
    run_op(10'h080, -1, 10, 7, -1);
    // Reset at shift 9, then a full operation from a known chain.
    run_op(10'h100, -1, -1, -1, 9);
    preload();
    run_op(10'h100, -1, -1, -1, -1);
`ifdef DSP_SCAN_PARITY_EN
    // Same data again with one lane-3 flip in the chain output.
    flip_at = 4;
    run_op(10'h100, -1, -1, -1, -1);
    flip_at = -1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
